// File: rtl/vec_operand_stage.sv
// vec_operand_stage: decode-to-execute operand capture stage of the vector ASIP.
// Registers a 4-lane operand bundle per accepted instruction; operand B comes
// from the register file or the constant vector bank.
// Build option: define VEC_OPSTAGE_SKID_EN for the two-entry skid build with a
// registered in_ready; otherwise a single output register with
// in_ready = !out_valid || out_ready.
module vec_operand_stage #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              in_opcode,
    input  logic [2:0]              in_rd,
    input  logic                    in_use_const,
    input  logic                    in_const_sel,
    input  logic [LANES*LANE_W-1:0] in_vra,
    input  logic [LANES*LANE_W-1:0] in_vrb,
    output logic                    const_rd_pos,
    input  logic [LANE_W-1:0]       const_l0,
    input  logic [LANE_W-1:0]       const_l1,
    input  logic [LANE_W-1:0]       const_l2,
    input  logic [LANE_W-1:0]       const_l3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              out_opcode,
    output logic [2:0]              out_rd,
    output logic [LANES*LANE_W-1:0] out_opa,
    output logic [LANES*LANE_W-1:0] out_opb
);
    localparam int unsigned VEC_W = LANES * LANE_W;
    localparam int unsigned OPC_W = 5;
    localparam int unsigned RD_W  = 3;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [RD_W-1:0]  rd;
        logic [VEC_W-1:0] opa;
        logic [VEC_W-1:0] opb;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t  state_q;
    state_t  state_d;
    bundle_t in_bundle;
    bundle_t out_q;
    logic    in_fire;
    logic    out_fire;
    logic    load_in;

`ifdef VEC_OPSTAGE_SKID_EN
    bundle_t skid_q;
    logic    in_ready_q;
    logic    load_skid;
    logic    pop_skid;

    assign in_ready = in_ready_q;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    // Bank half-select is passed straight through; the bank answers in the same cycle.
    assign const_rd_pos = in_const_sel;

    // Assemble the incoming bundle with the operand B source mux.
    always_comb begin
        in_bundle.opcode = in_opcode;
        in_bundle.rd     = in_rd;
        in_bundle.opa    = in_vra;
        in_bundle.opb    = in_use_const ? VEC_W'({const_l3, const_l2, const_l1, const_l0})
                                        : in_vrb;
    end

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign out_opcode = out_q.opcode;
    assign out_rd     = out_q.rd;
    assign out_opa    = out_q.opa;
    assign out_opb    = out_q.opb;

    // Occupancy next-state and register load controls; flush overrides all moves.
    always_comb begin
        state_d   = state_q;
        load_in   = 1'b0;
`ifdef VEC_OPSTAGE_SKID_EN
        load_skid = 1'b0;
        pop_skid  = 1'b0;
`endif
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        load_in = 1'b1;
                    end
                end
                ST_ONE: begin
`ifdef VEC_OPSTAGE_SKID_EN
                    if (in_fire && out_fire) begin
                        load_in = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
`else
                    if (in_fire) begin
                        load_in = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
`endif
                end
                ST_TWO: begin
`ifdef VEC_OPSTAGE_SKID_EN
                    if (out_fire) begin
                        state_d  = ST_ONE;
                        pop_skid = 1'b1;
                    end
`else
                    state_d = ST_EMPTY;
`endif
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State register plus the registered handshake outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            out_valid  <= 1'b0;
`ifdef VEC_OPSTAGE_SKID_EN
            in_ready_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            out_valid  <= (state_d != ST_EMPTY);
`ifdef VEC_OPSTAGE_SKID_EN
            in_ready_q <= (state_d != ST_TWO);
`endif
        end
    end

    // Bundle storage: output register and, in the skid build, the skid register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q  <= '0;
`ifdef VEC_OPSTAGE_SKID_EN
            skid_q <= '0;
`endif
        end else begin
            if (load_in) begin
                out_q <= in_bundle;
            end
`ifdef VEC_OPSTAGE_SKID_EN
            else if (pop_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_bundle;
            end else if (pop_skid) begin
                skid_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_vec_operand_stage.sv
// tb_vec_operand_stage: directed and random checks of vec_operand_stage against a
// queue-based reference model of the pipeline stage.
module tb_vec_operand_stage;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned VEC_W  = LANES * LANE_W;

    typedef struct packed {
        logic [4:0]       opcode;
        logic [2:0]       rd;
        logic [VEC_W-1:0] opa;
        logic [VEC_W-1:0] opb;
    } bun_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_opcode;
    logic [2:0]       in_rd;
    logic             in_use_const;
    logic             in_const_sel;
    logic [VEC_W-1:0] in_vra;
    logic [VEC_W-1:0] in_vrb;
    logic             const_rd_pos;
    logic [LANE_W-1:0] const_l0, const_l1, const_l2, const_l3;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_opcode;
    logic [2:0]       out_rd;
    logic [VEC_W-1:0] out_opa;
    logic [VEC_W-1:0] out_opb;

    bun_t       q[$];
    logic [4:0] emitted[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         armed    = 1'b0;
    bit         last_fire;

    vec_operand_stage #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd),
        .in_use_const(in_use_const), .in_const_sel(in_const_sel),
        .in_vra(in_vra), .in_vrb(in_vrb),
        .const_rd_pos(const_rd_pos),
        .const_l0(const_l0), .const_l1(const_l1), .const_l2(const_l2), .const_l3(const_l3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd),
        .out_opa(out_opa), .out_opb(out_opb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] rnd_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic present(input logic [4:0] opc);
        in_valid     = 1'b1;
        in_opcode    = opc;
        in_rd        = 3'($urandom_range(0, 7));
        in_use_const = 1'($urandom_range(0, 1));
        in_const_sel = 1'($urandom_range(0, 1));
        in_vra       = rnd_vec();
        in_vrb       = rnd_vec();
        const_l0     = $urandom();
        const_l1     = $urandom();
        const_l2     = $urandom();
        const_l3     = $urandom();
    endtask

    // One clock: check combinational outputs, advance the model at the edge, check registered outputs.
    task automatic cycle();
        bit   rdy;
        bit   outf;
        bun_t nb;
        #1;
`ifdef VEC_OPSTAGE_SKID_EN
        rdy = (q.size() < 2);
`else
        rdy = (q.size() == 0) || out_ready;
`endif
        if (armed) chk("in_ready", VEC_W'(in_ready), VEC_W'(rdy));
        chk("const_rd_pos", VEC_W'(const_rd_pos), VEC_W'(in_const_sel));
        nb.opcode = in_opcode;
        nb.rd     = in_rd;
        nb.opa    = in_vra;
        nb.opb    = in_use_const ? {const_l3, const_l2, const_l1, const_l0} : in_vrb;
        last_fire = rst && !flush && in_valid && rdy;
        outf      = rst && !flush && (q.size() > 0) && out_ready;
        if (outf) emitted.push_back(out_opcode);
        @(posedge clk);
        if (!rst) armed = 1'b1;
        if (!rst || flush) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (last_fire) q.push_back(nb);
        end
        #1;
        chk("out_valid", VEC_W'(out_valid), VEC_W'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_opcode", VEC_W'(out_opcode), VEC_W'(q[0].opcode));
            chk("out_rd", VEC_W'(out_rd), VEC_W'(q[0].rd));
            chk("out_opa", out_opa, q[0].opa);
            chk("out_opb", out_opb, q[0].opb);
        end
    endtask

    initial begin
        logic [VEC_W-1:0] saved_vra;
        logic [VEC_W-1:0] exp_opb;
        logic [4:0]       op;

        // Reset held two cycles with an instruction offered.
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        present(5'd9);
        cycle();
        cycle();
        chk("rst_opcode", VEC_W'(out_opcode), '0);
        chk("rst_rd", VEC_W'(out_rd), '0);
        chk("rst_opa", out_opa, '0);
        chk("rst_opb", out_opb, '0);
        rst = 1'b1; in_valid = 1'b0;
        cycle();
        chk("rel_ready", VEC_W'(in_ready), VEC_W'(1));

        // Constant bank upper half as operand B.
        present(5'd4);
        in_use_const = 1'b1; in_const_sel = 1'b1;
        const_l0 = 32'h44; const_l1 = 32'h55; const_l2 = 32'h66; const_l3 = 32'h77;
        saved_vra = in_vra;
        exp_opb = 128'h00000077_00000066_00000055_00000044;
        cycle();
        chk("const_opb", out_opb, exp_opb);
        chk("const_opa", out_opa, saved_vra);

        // Back-to-back streaming at full throughput.
        for (int i = 0; i < 8; i++) begin
            present(5'(i));
            cycle();
            chk("stream_opc", VEC_W'(out_opcode), VEC_W'(i));
        end
        in_valid = 1'b0;
        cycle();

        // Back-pressure with opcodes 1,2,3 held by decode until accepted.
        emitted.delete();
        out_ready = 1'b0;
        op = 5'd1;
        present(op);
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (last_fire && op < 5'd3) begin op = op + 5'd1; present(op); end
        end
        chk("bp_hold", VEC_W'(out_opcode), VEC_W'(1));
        chk("bp_ready", VEC_W'(in_ready), VEC_W'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_fire) begin
                if (op < 5'd3) begin op = op + 5'd1; present(op); end
                else in_valid = 1'b0;
            end
        end
        chk("bp_count", VEC_W'(emitted.size()), VEC_W'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < emitted.size()) chk("bp_order", VEC_W'(emitted[i]), VEC_W'(i + 1));
        end

        // Flush while full; the offered instruction must never appear.
        out_ready = 1'b0;
        present(5'd10);
        cycle();
        if (last_fire) present(5'd11);
        cycle();
        emitted.delete();
        flush = 1'b1;
        present(5'd31);
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_valid", VEC_W'(out_valid), VEC_W'(0));
        chk("flush_ready", VEC_W'(in_ready), VEC_W'(1));
        repeat (3) cycle();
        chk("flush_drop", VEC_W'(emitted.size()), VEC_W'(0));

        // Flush while an input fire is possible.
        present(5'd1);
        cycle();
        emitted.delete();
        flush = 1'b1;
        present(5'd31);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        chk("flush_fire_valid", VEC_W'(out_valid), VEC_W'(0));
        chk("flush_fire_drop", VEC_W'(emitted.size()), VEC_W'(0));

        // Reset mid-operation drops held bundles and zeroes the outputs.
        out_ready = 1'b0;
        present(5'd7);
        cycle();
        present(5'd8);
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1; in_valid = 1'b0;
        chk("mid_rst_valid", VEC_W'(out_valid), VEC_W'(0));
        chk("mid_rst_opa", out_opa, '0);
        chk("mid_rst_opc", VEC_W'(out_opcode), '0);
        cycle();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            present(5'($urandom_range(0, 31)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 63) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_operand_stage.md
# vec_operand_stage

Decode-to-execute pipeline stage of the vector ASIP. Each accepted instruction captures its vector operands into a registered 4-lane operand bundle for the execute stage. Operand B is taken either from the vector register file or from the constant vector bank; this block drives the bank's half-select (`const_rd_pos`) and consumes its four lane outputs. A valid/ready handshake with an optional 2-entry skid buffer decouples execute back-pressure from decode.

## Interface
Parameters:
- `LANES`, 4: vector lanes; fixed at 4, matching the constant bank.
- `LANE_W`, 32: bits per lane.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous and active-low.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage can accept.
- `in_opcode`  in  5  operation code.
- `in_rd`  in  3  destination vector register.
- `in_use_const`  in  1  1: operand B comes from the constant bank.
- `in_const_sel`  in  1  constant bank half: 0 = entries 0–3, 1 = entries 4–7.
- `in_vra`  in  LANES*LANE_W  operand A from the register file; lane 0 = bits [31:0].
- `in_vrb`  in  LANES*LANE_W  operand B from the register file.
- `const_rd_pos`  out  1  to the constant bank's `rd_pos`.
- `const_l0`..`const_l3`  in  LANE_W each  bank outputs `out1`..`out4`.
- `out_valid`  out  1  bundle valid to execute.
- `out_ready`  in  1  execute accepts.
- `out_opcode`  out  5
- `out_rd`  out  3
- `out_opa`  out  LANES*LANE_W
- `out_opb`  out  LANES*LANE_W

## Operation
- `const_rd_pos = in_const_sel`. This is combinational; the bank is combinational, so constants are valid in the same cycle.
- Operand B mux: if `in_use_const`, then `{const_l3,const_l2,const_l1,const_l0}`; otherwise `in_vrb`.
- Input fire = `in_valid && in_ready`. Output fire = `out_valid && out_ready`.
- The output bundle is registered. `out_*` fields are held stable while `out_valid && !out_ready`.
- Occupancy FSM (skid build): EMPTY, ONE, TWO.
  - EMPTY + in fire → ONE. The bundle loads into the output register.
  - ONE + in fire + out fire → ONE. The output register reloads with the new bundle.
  - ONE + in fire, no out fire → TWO. The new bundle goes to the skid register.
  - ONE + out fire, no in fire → EMPTY.
  - TWO + out fire → ONE. The skid register moves to the output register and the skid is cleared.
  - TWO never accepts input.
- `in_ready` is registered: 1 in EMPTY and ONE, 0 in TWO.
- `flush` has priority over everything. Next state is EMPTY, `out_valid`=0, and any input fire in the flush cycle is discarded.
- Order is preserved: bundles leave in acceptance order.

## Timing
- Latency: 1 cycle. A bundle accepted at edge N is presented with `out_valid`=1 after edge N.
- Throughput: 1 bundle per cycle while `out_ready`=1.
- `rst` low at an edge has these effects:
  - FSM goes to EMPTY.
  - `out_valid`=0, and `out_opcode`, `out_rd`, `out_opa`, `out_opb` = 0.
  - Skid register is cleared to 0.
  - `in_ready`=1 from the first edge after `rst` rises; it reads 1 while in reset, but fires in a cycle with `rst` low are ignored.
- Reset mid-operation drops both held bundles. No partial output is produced.
- `flush` and `rst` together: reset values apply.

## Configuration
- `VEC_OPSTAGE_SKID_EN` defined:
  - Two-entry buffer as above.
  - `in_ready` is registered, with no combinational path from `out_ready`.
- Not defined:
  - Single output register; state is EMPTY or ONE only.
  - `in_ready = !out_valid || out_ready` (combinational).
  - Reset, flush and latency rules are unchanged.

## Test plan
- Reset: `rst`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, all outputs 0. After release, `in_ready`=1.
- Constant select:
  - `in_use_const`=1, `in_const_sel`=1, bank lanes 0x44,0x55,0x66,0x77 → `const_rd_pos`=1 the same cycle.
  - Next cycle `out_opb`=0x00000077_00000066_00000055_00000044.
  - `in_vra` passes to `out_opa` unchanged.
- Streaming: 8 back-to-back bundles, opcode 0..7, `out_ready`=1 → outputs in order, one per cycle, first one cycle after first accept.
- Back-pressure (skid build):
  - `out_ready`=0 while feeding opcodes 1,2,3 → opcode 1 held at output, opcode 2 skidded, `in_ready`=0, opcode 3 not accepted.
  - After `out_ready`=1 → 1,2,3 emitted in order.
- Flush: state TWO, then `flush`=1 with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, flushed input never appears.
- Macro off, same back-pressure sequence → `in_ready` follows `out_ready` in the same cycle; no bundle lost or duplicated.
